// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous-read Data_RAM.
// Tie-break: fixed priority to requester 0 unless RAM_ARB_ROUND_ROBIN_EN is defined.
module ram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic              ram_we_q,    ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              rd1_v_q,  rd1_v_d;
  logic              rd1_id_q, rd1_id_d;
  logic              rd2_v_q,  rd2_v_d;
  logic              rd2_id_q, rd2_id_d;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  typedef enum logic {PRI_REQ0 = 1'b0, PRI_REQ1 = 1'b1} prio_e;
  prio_e prio_q, prio_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req0 && req1) begin
        if (prio_q == PRI_REQ0) gnt0 = 1'b1;
        else                    gnt1 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Pointer favours whichever requester was not granted last.
  always_comb begin
    prio_d = prio_q;
    if (gnt0)      prio_d = PRI_REQ1;
    else if (gnt1) prio_d = PRI_REQ0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= PRI_REQ0;
    else        prio_q <= prio_d;
  end
`else
  always_comb begin
    gnt0 = rst_n & req0;
    gnt1 = rst_n & req1 & ~req0;
  end
`endif

  always_comb begin
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rd1_v_d     = 1'b0;
    rd1_id_d    = 1'b0;
    if (gnt0) begin
      ram_we_d    = we0;
      ram_addr_d  = addr0;
      ram_wdata_d = wdata0;
      rd1_v_d     = ~we0;
      rd1_id_d    = 1'b0;
    end else if (gnt1) begin
      ram_we_d    = we1;
      ram_addr_d  = addr1;
      ram_wdata_d = wdata1;
      rd1_v_d     = ~we1;
      rd1_id_d    = 1'b1;
    end
    // Second tag stage lines up with the RAM's one-cycle read latency.
    rd2_v_d  = rd1_v_q;
    rd2_id_d = rd1_id_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd1_v_q     <= 1'b0;
      rd1_id_q    <= 1'b0;
      rd2_v_q     <= 1'b0;
      rd2_id_q    <= 1'b0;
    end else begin
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rd1_v_q     <= rd1_v_d;
      rd1_id_q    <= rd1_id_d;
      rd2_v_q     <= rd2_v_d;
      rd2_id_q    <= rd2_id_d;
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign rvalid0   = rd2_v_q & ~rd2_id_q;
  assign rvalid1   = rd2_v_q &  rd2_id_q;
  assign rdata0    = ram_rdata;
  assign rdata1    = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus random traffic
// against a transaction-level model (grant rule, memory array, return schedule).
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, we0, we1;
  logic [9:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  ram_arbiter #(.ADDR_W(10), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Data_RAM stand-in: synchronous read, one cycle latency.
  logic [7:0] ram_mem [1024];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] mem_m [1024];
  logic       p_act [2];
  logic       p_we  [2];
  logic [9:0] p_addr[2];
  logic [7:0] p_wd  [2];
  logic       ev  [4];
  logic       eid [4];
  logic [7:0] ed  [4];
  logic       exp_we;
  logic [9:0] exp_addr;
  logic [7:0] exp_wd;
  int         last_win;
  int         cyc;
  logic [7:0] seq;
  logic       g_any;
  logic [7:0] last_rd0;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ev[i] = 1'b0;
    for (int i = 0; i < 2; i++) p_act[i] = 1'b0;
    exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
    last_win = 1;
  endtask

  task automatic step();
    logic g0, g1;
    int   w, slot, nxt;
    @(negedge clk);
    req0 = p_act[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wd[0];
    req1 = p_act[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wd[1];
    #1;
    g0 = 1'b0; g1 = 1'b0;
    if (p_act[0] && p_act[1]) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      if (last_win == 0) g1 = 1'b1; else g0 = 1'b1;
`else
      g0 = 1'b1;
`endif
    end else begin
      g0 = p_act[0];
      g1 = p_act[1];
    end
    check("gnt0", 32'(gnt0), 32'(g0));
    check("gnt1", 32'(gnt1), 32'(g1));
    slot = cyc % 4;
    check("rvalid0", 32'(rvalid0), 32'(ev[slot] && !eid[slot]));
    check("rvalid1", 32'(rvalid1), 32'(ev[slot] && eid[slot]));
    if (ev[slot]) check("rdata", 32'(eid[slot] ? rdata1 : rdata0), 32'(ed[slot]));
    if (rvalid0) last_rd0 = rdata0;
    ev[slot] = 1'b0;
    check("ram_we", 32'(ram_we), 32'(exp_we));
    check("ram_addr", 32'(ram_addr), 32'(exp_addr));
    check("ram_wdata", 32'(ram_wdata), 32'(exp_wd));
    exp_we = 1'b0;
    g_any = g0 | g1;
    if (g_any) begin
      w = g1 ? 1 : 0;
      last_win = w;
      seq = {seq[6:0], g1};
      if (p_we[w]) begin
        mem_m[p_addr[w]] = p_wd[w];
        exp_we = 1'b1;
      end else begin
        nxt = (cyc + 2) % 4;
        ev[nxt]  = 1'b1;
        eid[nxt] = g1;
        ed[nxt]  = mem_m[p_addr[w]];
      end
      exp_addr = p_addr[w];
      exp_wd   = p_wd[w];
      p_act[w] = 1'b0;
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic issue(input int id, input logic we, input logic [9:0] a, input logic [7:0] d);
    int n;
    p_act[id] = 1'b1; p_we[id] = we; p_addr[id] = a; p_wd[id] = d;
    n = 0;
    while (p_act[id] && n < 8) begin
      step();
      n++;
    end
    if (p_act[id]) begin
      check("grant_timeout", 32'd1, 32'd0);
      p_act[id] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int iss0, iss1, guard;
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = '0;
      mem_m[i]   = '0;
    end
    ram_rdata = '0;
    cyc = 0; seq = '0; last_rd0 = '0;
    model_reset();
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b0;
    addr0 = 10'h155; addr1 = 10'h2AA; wdata0 = 8'h33; wdata1 = 8'h44;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);

    // Back-to-back writes then reads from requester 0
    issue(0, 1'b1, 10'h000, 8'hFF);
    issue(0, 1'b1, 10'h002, 8'hAA);
    issue(0, 1'b1, 10'h003, 8'hF0);
    issue(0, 1'b0, 10'h000, 8'h00);
    issue(0, 1'b0, 10'h002, 8'h00);
    issue(0, 1'b0, 10'h003, 8'h00);
    idle(3);
    check("seq_read_last", 32'(last_rd0), 32'hF0);

    // Reset one cycle after a read is accepted
    issue(0, 1'b0, 10'h002, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h1C3;
    #1;
    check("mid_rst_gnt0", 32'(gnt0), 32'd0);
    check("mid_rst_ram_we", 32'(ram_we), 32'd0);
    check("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
    check("mid_rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req0 = 1'b0;
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
    @(posedge clk);
    idle(4);

    // Contention: both requesters present four reads each
    seq = '0; iss0 = 0; iss1 = 0; guard = 0;
    while ((iss0 < 4 || iss1 < 4 || p_act[0] || p_act[1]) && guard < 20) begin
      if (!p_act[0] && iss0 < 4) begin
        p_act[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 10'h010; iss0++;
      end
      if (!p_act[1] && iss1 < 4) begin
        p_act[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 10'h020; iss1++;
      end
      step();
      guard++;
    end
`ifdef RAM_ARB_ROUND_ROBIN_EN
    check("contention_order", 32'(seq), 32'h55);
`else
    check("contention_order", 32'(seq), 32'h0F);
`endif
    idle(3);

    // Write then immediate read at the top address from the other requester
    issue(1, 1'b1, 10'h3FF, 8'h5A);
    issue(0, 1'b0, 10'h3FF, 8'h00);
    idle(3);
    check("hazard_rdata0", 32'(last_rd0), 32'h5A);

    idle(10);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_act[i] && $urandom_range(0, 3) != 0) begin
          p_act[i]  = 1'b1;
          p_we[i]   = 1'($urandom_range(0, 1));
          p_addr[i] = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
          p_wd[i]   = 8'($urandom);
        end
      end
      step();
    end
    p_act[0] = 1'b0; p_act[1] = 1'b0;
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning RAM address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning RAM data width in bits.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have ports req0/req1  input  1  access request from requester 0/1.
REQ-006 The block SHALL have ports we0/we1  input  1  1 = write, 0 = read, for the matching request.
REQ-007 The block SHALL have ports addr0/addr1  input  ADDR_W  request address.
REQ-008 The block SHALL have ports wdata0/wdata1  input  DATA_W  write data.
REQ-009 The block SHALL have ports gnt0/gnt1  output  1  request accepted at this rising edge (combinational).
REQ-010 The block SHALL have ports rvalid0/rvalid1  output  1  read data valid for requester 0/1 (registered).
REQ-011 The block SHALL have ports rdata0/rdata1  output  DATA_W  read data, equal to ram_rdata, qualified by rvalid.
REQ-012 The block SHALL have port ram_we  output  1  write enable to Data_RAM write_enable (registered).
REQ-013 The block SHALL have port ram_addr  output  ADDR_W  to Data_RAM address (registered).
REQ-014 The block SHALL have port ram_wdata  output  DATA_W  to Data_RAM data_in (registered).
REQ-015 The block SHALL have port ram_rdata  input  DATA_W  from Data_RAM data_out (synchronous read, 1-cycle latency).

Function
REQ-016 Requester holds req, we, addr, wdata stable until it sees gnt high at a rising edge; acceptance = req & gnt at that edge.
REQ-017 At most one of gnt0/gnt1 high in any cycle; gntX never high while reqX low.
REQ-018 Single active requester is granted in the same cycle; no idle cycles; throughput one access per clock.
REQ-019 Both requesting: winner chosen by priority pointer (see Configuration); loser keeps req high and waits.
REQ-020 On acceptance edge E0: ram_addr, ram_wdata, ram_we load from the winner; with no acceptance, ram_we loads 0 and ram_addr/ram_wdata hold.
REQ-021 ram_we high for exactly one cycle per accepted write; back-to-back writes keep ram_we high continuously.
REQ-022 Read accepted at E0: RAM samples address at E1; rvalidX high for exactly the one cycle following E1 (two edges after acceptance).
REQ-023 Read tag pipeline is 2 stages, 1 bit valid + 1 bit requester id; back-to-back reads from mixed requesters return in acceptance order, one per cycle.
REQ-024 Write followed immediately by read to the same address returns the newly written data (Data_RAM write-first at E1 not required: write lands at E1, read samples at E2).
REQ-025 rvalid0 and rvalid1 never high together.

Reset
REQ-026 rst_n low asynchronously forces ram_we=0, ram_addr=0, ram_wdata=0, rvalid0=rvalid1=0, tag pipeline cleared, priority pointer = requester 0.
REQ-027 Reads in flight at reset are discarded; no rvalid issued for them after rst_n rises.
REQ-028 gnt0/gnt1 forced 0 while rst_n low; first acceptance possible at first rising edge with rst_n high.

Configuration
REQ-029 Macro RAM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests the requester not granted most recently wins; pointer updates on every acceptance; any waiting requester is granted within 2 cycles.
REQ-030 Macro RAM_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins ties; pointer logic absent; requester 1 may starve.

Verification
REQ-031 Reset: rst_n=0 mid-read (one cycle after acceptance) -> rvalid0/rvalid1 stay 0 after release, ram_we=0, ram_addr=0.
REQ-032 Single requester: req0 write 0xFF@0, 0xAA@2, 0xF0@3 back-to-back, then reads @0,2,3 -> gnt0 every cycle, rvalid0 three consecutive cycles with rdata0 = 0xFF, 0xAA, 0xF0.
REQ-033 Contention, round-robin build: req0 and req1 both held for 4 reads (addr 0x010 / 0x020) -> gnt alternates 0,1,0,1 starting with 0 after reset; rvalid ids follow same order.
REQ-034 Contention, fixed-priority build: same stimulus -> gnt0 for all of requester 0's requests first, then gnt1.
REQ-035 Hazard: req1 write 0x5A@0x3FF, next cycle req0 read @0x3FF -> rvalid0 with rdata0=0x5A; write at top address 0x3FF lands without wrap.
REQ-036 Idle: no req for 10 cycles -> gnt0=gnt1=0, ram_we=0, ram_addr unchanged, no rvalid.
